// File: rtl/tnn_spike_encoder.sv
// Pixel-to-spike-time encoder for the TNN column: loads a receptive field over valid/ready
// into a load buffer and replays it as a volley while the next field fills.
module tnn_spike_encoder #(
    parameter int unsigned TIME_PERIOD     = 8,
    parameter int unsigned RECEPTIVE_FIELD = 16,
    parameter int unsigned PIX_BITS        = 8,
    parameter int unsigned THRESH          = 32
) (
    input  logic                                                 clk,
    input  logic                                                 rst_l,
    input  logic [PIX_BITS-1:0]                                  pix_data,
    input  logic                                                 pix_valid,
    output logic                                                 pix_ready,
    output logic [$clog2(TIME_PERIOD):0]                         time_val,
    output logic [RECEPTIVE_FIELD*($clog2(TIME_PERIOD)+1)-1:0]   spike_times,
    output logic                                                 volley_start,
    output logic                                                 busy,
    output logic [15:0]                                          volley_count
);

    localparam int unsigned TBITS = $clog2(TIME_PERIOD);
    localparam int unsigned EW    = TBITS + 1;
    localparam int unsigned SW    = RECEPTIVE_FIELD * EW;
    localparam int unsigned CW    = $clog2(RECEPTIVE_FIELD + 1);
    localparam int unsigned PMAX  = (1 << PIX_BITS) - 1;
    localparam logic [EW-1:0] NO_SPIKE = {1'b1, {TBITS{1'b0}}};

    typedef enum logic {IDLE, RUN} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
    logic [SW-1:0]  load_q, load_d;
    logic [SW-1:0]  spike_times_q, spike_times_d;
    logic [EW-1:0]  time_val_q, time_val_d;
    logic           volley_start_q, volley_start_d;
    logic           busy_q, busy_d;
    logic [15:0]    volley_count_q, volley_count_d;
    logic           pix_ready_q, pix_ready_d;

    logic [EW-1:0]  enc_entry;
    int unsigned    enc_prod;
    logic           accept;
    logic           full;
    logic           last;
    logic           swap;

    // Early-is-strong encoding: brighter pixels fire earlier in the gamma cycle.
    always_comb begin
        enc_prod = (PMAX - 32'(pix_data)) * TIME_PERIOD;
        if (32'(pix_data) < THRESH) begin
            enc_entry = NO_SPIKE;
        end else begin
            enc_entry = {1'b0, TBITS'(enc_prod >> PIX_BITS)};
        end
    end

    assign accept = pix_valid && pix_ready_q;
    assign full   = (fill_cnt_q == CW'(RECEPTIVE_FIELD));
    assign last   = (state_q == RUN) && (time_val_q == EW'(TIME_PERIOD - 1));
    assign swap   = full && ((state_q == IDLE) || last);

    always_comb begin
        state_d        = state_q;
        fill_cnt_d     = fill_cnt_q;
        load_d         = load_q;
        spike_times_d  = spike_times_q;
        time_val_d     = time_val_q;
        volley_start_d = 1'b0;
        volley_count_d = volley_count_q;

        for (int unsigned i = 0; i < RECEPTIVE_FIELD; i++) begin
            if (accept && (fill_cnt_q == CW'(i))) begin
                load_d[i*EW +: EW] = enc_entry;
            end
        end
        if (accept) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                time_val_d = '0;
            end
            RUN: begin
                if (last) begin
                    volley_count_d = volley_count_q + 16'd1;
                    state_d        = IDLE;
                    time_val_d     = '0;
                    spike_times_d  = {RECEPTIVE_FIELD{NO_SPIKE}};
                end else begin
                    time_val_d = time_val_q + EW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Swap overrides the end-of-volley return to IDLE for gap-free volleys.
        if (swap) begin
            state_d        = RUN;
            spike_times_d  = load_q;
            fill_cnt_d     = '0;
            time_val_d     = '0;
            volley_start_d = 1'b1;
        end

        busy_d      = (state_d == RUN);
        pix_ready_d = (fill_cnt_d < CW'(RECEPTIVE_FIELD));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q        <= IDLE;
            fill_cnt_q     <= '0;
            load_q         <= {RECEPTIVE_FIELD{NO_SPIKE}};
            spike_times_q  <= {RECEPTIVE_FIELD{NO_SPIKE}};
            time_val_q     <= '0;
            volley_start_q <= 1'b0;
            busy_q         <= 1'b0;
            volley_count_q <= '0;
            pix_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            load_q         <= load_d;
            spike_times_q  <= spike_times_d;
            time_val_q     <= time_val_d;
            volley_start_q <= volley_start_d;
            busy_q         <= busy_d;
            volley_count_q <= volley_count_d;
            pix_ready_q    <= pix_ready_d;
        end
    end

    assign pix_ready    = pix_ready_q;
    assign time_val     = time_val_q;
    assign spike_times  = spike_times_q;
    assign volley_start = volley_start_q;
    assign busy         = busy_q;
    assign volley_count = volley_count_q;

endmodule

// File: tb/tb_tnn_spike_encoder.sv
// Randomized bench for tnn_spike_encoder: a volley-level scoreboard for the default config
// plus a small RF=1/TP=2 instance for back-to-back volleys and volley_count wrap.
module tb_tnn_spike_encoder;

    localparam int unsigned TP = 8;
    localparam int unsigned RF = 16;
    localparam int unsigned PB = 8;
    localparam int unsigned TH = 32;
    localparam int unsigned EW = 4;
    localparam logic [63:0] NS_ALL = {16{4'b1000}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l, pix_valid, pix_ready, volley_start, busy;
    logic [7:0]  pix_data;
    logic [3:0]  time_val;
    logic [63:0] spike_times;
    logic [15:0] volley_count;

    logic        rst_fl, pix_valid_f, pix_ready_f, volley_start_f, busy_f;
    logic [7:0]  pix_data_f;
    logic [1:0]  time_val_f;
    logic [1:0]  spike_times_f;
    logic [15:0] volley_count_f;

    tnn_spike_encoder #(.TIME_PERIOD(TP), .RECEPTIVE_FIELD(RF), .PIX_BITS(PB), .THRESH(TH)) dut (
        .clk(clk), .rst_l(rst_l), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .time_val(time_val), .spike_times(spike_times),
        .volley_start(volley_start), .busy(busy), .volley_count(volley_count)
    );

    tnn_spike_encoder #(.TIME_PERIOD(2), .RECEPTIVE_FIELD(1), .PIX_BITS(8), .THRESH(32)) dut_f (
        .clk(clk), .rst_l(rst_fl), .pix_data(pix_data_f), .pix_valid(pix_valid_f),
        .pix_ready(pix_ready_f), .time_val(time_val_f), .spike_times(spike_times_f),
        .volley_start(volley_start_f), .busy(busy_f), .volley_count(volley_count_f)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Spike entry from the intensity rule: flag value when dark, else scaled inverse intensity.
    function automatic int enc(input int p, input int tp, input int flag);
        if (p < int'(TH)) return flag;
        return ((255 - p) * tp) / 256;
    endfunction

    // Volley-level scoreboard for the default instance.
    int          acc[$];
    logic [63:0] vq[$];
    logic [63:0] cur;
    bit          in_vol, prev_last, exp_start;
    int          tv_exp, cnt_m;

    always @(negedge clk) begin
        if (!rst_l) begin
            acc.delete(); vq.delete();
            in_vol = 0; prev_last = 0; exp_start = 0; tv_exp = 0; cnt_m = 0; cur = NS_ALL;
        end else begin
            check("volley_start", 64'(volley_start), 64'(exp_start));
            if (prev_last) cnt_m++;
            if (volley_start) begin
                if (vq.size() == 0) check("volley_without_image", 64'(vq.size()), 64'd1);
                else cur = vq.pop_front();
                in_vol = 1; tv_exp = 0;
            end else if (prev_last) begin
                in_vol = 0;
            end else if (in_vol) begin
                tv_exp++;
            end
            check("busy", 64'(busy), 64'(in_vol));
            check("time_val", 64'(time_val), in_vol ? 64'(tv_exp) : 64'd0);
            check("spike_times", spike_times, in_vol ? cur : NS_ALL);
            check("volley_count", 64'(volley_count), 64'(cnt_m & 16'hFFFF));
            check("pix_ready", 64'(pix_ready), 64'(vq.size() == 0));
            exp_start = (!in_vol || tv_exp == int'(TP) - 1) && (vq.size() > 0);
            prev_last = in_vol && (tv_exp == int'(TP) - 1);
            if (pix_valid && pix_ready) begin
                acc.push_back(int'(pix_data));
                if (acc.size() == int'(RF)) begin
                    logic [63:0] v;
                    for (int i = 0; i < int'(RF); i++) v[i*EW +: EW] = 4'(enc(acc[i], TP, 8));
                    vq.push_back(v);
                    acc.delete();
                end
            end
        end
    end

    // Fast instance: with valid held high every volley is two cycles, back to back.
    int fq[$];
    bit f_en = 0;
    bit f_started = 0;
    bit f_ph = 0;

    always @(negedge clk) begin
        if (rst_fl && f_en) begin
            if (!f_started && volley_start_f) begin
                f_started = 1; f_ph = 0;
            end else if (f_started) begin
                f_ph = ~f_ph;
            end
            if (f_started) begin
                check("f_volley_start", 64'(volley_start_f), 64'(f_ph == 0));
                check("f_time_val", 64'(time_val_f), 64'(f_ph));
                check("f_busy", 64'(busy_f), 64'd1);
                check("f_pix_ready", 64'(pix_ready_f), 64'(f_ph == 0));
                if (f_ph == 0) begin
                    if (fq.size() == 0) check("f_volley_without_pixel", 64'(fq.size()), 64'd1);
                    else check("f_spike", 64'(spike_times_f), 64'(enc(fq.pop_front(), 2, 2)));
                end
            end
            if (pix_valid_f && pix_ready_f) fq.push_back(int'(pix_data_f));
        end
    end

    task automatic send(input logic [7:0] p, input int bub);
        int  n;
        logic rdy;
        for (int k = 0; k < 4 && bub > 0 && $urandom_range(99) < bub; k++) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_data = p; pix_valid = 1'b1; n = 0;
        do begin
            rdy = pix_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check("send_accept", 64'(rdy), 64'd1);
        pix_valid = 1'b0;
    endtask

    task automatic wait_volley();
        int n = 0;
        while (!busy && n < 60) begin @(negedge clk); n++; end
        check("volley_begins", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 60) begin @(negedge clk); n++; end
        check("volley_ends", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ready"}, 64'(pix_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_time_val"}, 64'(time_val), 64'd0);
        check({tag, "_spikes"}, spike_times, NS_ALL);
        check({tag, "_vstart"}, 64'(volley_start), 64'd0);
        check({tag, "_vcount"}, 64'(volley_count), 64'd0);
    endtask

    initial begin
        logic [7:0]  img [16];
        logic [63:0] sp;
        logic [15:0] vc0;
        int          n;

        rst_l = 1'b0; rst_fl = 1'b0; pix_valid = 1'b0; pix_data = '0;
        pix_valid_f = 1'b0; pix_data_f = '0;
        repeat (3) @(posedge clk); #1;
        check_reset_vals("rst");
        rst_l = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_reset_vals("idle20");

        // Directed image from the intensity table.
        img = '{8'd255, 8'd128, 8'd32, 8'd31, 8'd0, 8'd200, 8'd200, 8'd200,
                8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        for (int i = 0; i < 16; i++) send(img[i], 0);
        @(negedge clk);
        check("lat_e0_vstart", 64'(volley_start), 64'd0);
        @(negedge clk);
        check("lat_e1_vstart", 64'(volley_start), 64'd1);
        check("lat_e1_busy", 64'(busy), 64'd1);
        check("lat_e1_tv", 64'(time_val), 64'd0);
        sp = spike_times;
        check("entry0", 64'(sp[0 +: 4]), 64'b0000);
        check("entry1", 64'(sp[4 +: 4]), 64'b0011);
        check("entry2", 64'(sp[8 +: 4]), 64'b0110);
        check("entry3", 64'(sp[12 +: 4]), 64'b1000);
        check("entry4", 64'(sp[16 +: 4]), 64'b1000);
        check("entry5", 64'(sp[20 +: 4]), 64'b0001);
        check("entry15", 64'(sp[60 +: 4]), 64'b0001);
        wait_volley();
        check("directed_vcount", 64'(volley_count), 64'd1);

        // Three images streamed continuously, then three with random valid bubbles.
        vc0 = volley_count;
        for (int i = 0; i < 48; i++) send(8'($urandom_range(255)), 0);
        wait_volley();
        check("stream_vcount", 64'(volley_count), 64'(vc0 + 16'd3));
        vc0 = volley_count;
        for (int i = 0; i < 48; i++) send(8'($urandom_range(255)), 40);
        wait_volley();
        check("bubble_vcount", 64'(volley_count), 64'(vc0 + 16'd3));

        // Reset mid-volley with a partial load pending.
        for (int i = 0; i < 16; i++) send(8'($urandom_range(255)), 0);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(255)), 0);
        n = 0;
        while (time_val != 4'd4 && n < 20) begin @(posedge clk); #1; n++; end
        check("pre_reset_tv", 64'(time_val), 64'd4);
        rst_l = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk); #1;
        rst_l = 1'b1;
        for (int i = 0; i < 16; i++) send(8'($urandom_range(255)), 20);
        wait_volley();
        check("post_reset_vcount", 64'(volley_count), 64'd1);

        // Fast config: back-to-back volleys, then run to the volley_count wrap.
        @(posedge clk); #1;
        rst_fl = 1'b1; pix_valid_f = 1'b1; f_en = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            pix_data_f = 8'($urandom_range(255));
        end
        f_en = 0;
        check("f_started", 64'(f_started), 64'd1);
        n = 0;
        while (volley_count_f != 16'hFFFF && n < 140000) begin @(negedge clk); n++; end
        check("f_vcount_max", 64'(volley_count_f), 64'hFFFF);
        n = 0;
        while (volley_count_f == 16'hFFFF && n < 8) begin @(negedge clk); n++; end
        check("f_vcount_wrap", 64'(volley_count_f), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
